// File: rtl/pc_fetch.sv
// pc_fetch: program counter and in-order instruction fetch front end.
// Issues requests to instruction memory and buffers responses in a 2-entry FIFO.
// It presents {pc, inst, valid} to IF/ID and honours stall and redirect.
// Optional feature: define PC_ALIGN_CHECK_EN to force word-aligned jump
// targets and to pulse misalign_o.
// Ports:
//   clk_100MHz, arst_n              clock, async active-low reset
//   hold_ena_i                      global stall
//   jump_ena_i, jump_addr_i         redirect strobe and target
//   imem_req_o, imem_addr_o         fetch request (req & ready = accept)
//   imem_ready_i                    memory accepts the request
//   imem_rvalid_i, imem_rdata_i     in-order fetch response
//   if_valid_o, if_pc_o, if_inst_o  registered instruction to IF/ID
//   misalign_o                      misaligned-jump pulse
module pc_fetch #(
    parameter int unsigned       ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter logic [31:0]       NOP_INST = 32'h0000_0013
) (
    input  logic              clk_100MHz,
    input  logic              arst_n,
    input  logic              hold_ena_i,
    input  logic              jump_ena_i,
    input  logic [ADDR_W-1:0] jump_addr_i,
    output logic              imem_req_o,
    output logic [ADDR_W-1:0] imem_addr_o,
    input  logic              imem_ready_i,
    input  logic              imem_rvalid_i,
    input  logic [31:0]       imem_rdata_i,
    output logic              if_valid_o,
    output logic [ADDR_W-1:0] if_pc_o,
    output logic [31:0]       if_inst_o,
    output logic              misalign_o
);

    typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q;
    logic [1:0]        out_cnt_q, fifo_cnt_q, drop_cnt_q, drop_nxt;
    logic [1:0]        tag_cnt_q;
    logic [ADDR_W-1:0] tag0_q, tag1_q;
    logic [ADDR_W-1:0] fpc0_q, fpc1_q;
    logic [31:0]       fin0_q, fin1_q;
    logic [ADDR_W-1:0] jmp_target;

    logic accept, rsp, rsp_live, credit_ok;
    logic fifo_pop, fifo_push, bypass, tag_pop;

    assign imem_addr_o = pc_q;
    assign accept      = imem_req_o & imem_ready_i;
    // A response with nothing outstanding is stale (e.g. from before reset).
    assign rsp         = imem_rvalid_i & (out_cnt_q != 2'd0);
    assign rsp_live    = rsp & (drop_cnt_q == 2'd0) & ~jump_ena_i;
    // In-flight plus buffered never exceeds the FIFO depth.
    assign credit_ok   = ({1'b0, out_cnt_q} + {1'b0, fifo_cnt_q}) < 3'd2;
    assign fifo_pop    = ~jump_ena_i & ~hold_ena_i & (fifo_cnt_q != 2'd0);
    assign fifo_push   = rsp_live & (hold_ena_i | (fifo_cnt_q != 2'd0));
    assign bypass      = rsp_live & ~hold_ena_i & (fifo_cnt_q == 2'd0);
    // Tags only exist for responses that will be kept.
    assign tag_pop     = rsp & (drop_cnt_q == 2'd0);

`ifdef PC_ALIGN_CHECK_EN
    logic misalign_q;
    assign jmp_target = {jump_addr_i[ADDR_W-1:2], 2'b00};
    assign misalign_o = misalign_q;
    always_ff @(posedge clk_100MHz or negedge arst_n) begin
        if (!arst_n) misalign_q <= 1'b0;
        else         misalign_q <= jump_ena_i & (jump_addr_i[1:0] != 2'b00);
    end
`else
    assign jmp_target = jump_addr_i;
    assign misalign_o = 1'b0;
`endif

    // Responses still owed by memory that belong to the old path.
    always_comb begin
        drop_nxt = drop_cnt_q;
        if (jump_ena_i)
            drop_nxt = out_cnt_q - {1'b0, rsp};
        else if (rsp && drop_cnt_q != 2'd0)
            drop_nxt = drop_cnt_q - 2'd1;
    end

    always_ff @(posedge clk_100MHz or negedge arst_n) begin
        if (!arst_n) state_q <= IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    state_d = RUN;
            RUN:     state_d = (jump_ena_i && drop_nxt != 2'd0) ? FLUSH : RUN;
            FLUSH:   state_d = (drop_nxt == 2'd0) ? RUN : FLUSH;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        imem_req_o = (state_q != IDLE) & ~hold_ena_i & ~jump_ena_i & credit_ok;
    end

    always_ff @(posedge clk_100MHz or negedge arst_n) begin
        if (!arst_n) begin
            pc_q       <= RESET_PC;
            out_cnt_q  <= 2'd0;
            drop_cnt_q <= 2'd0;
        end else begin
            out_cnt_q  <= out_cnt_q + {1'b0, accept} - {1'b0, rsp};
            drop_cnt_q <= drop_nxt;
            if (jump_ena_i)  pc_q <= jmp_target;
            else if (accept) pc_q <= pc_q + ADDR_W'(4);
        end
    end

    always_ff @(posedge clk_100MHz or negedge arst_n) begin
        if (!arst_n) begin
            tag_cnt_q <= 2'd0;
            tag0_q    <= '0;
            tag1_q    <= '0;
        end else if (jump_ena_i) begin
            tag_cnt_q <= 2'd0;
        end else begin
            case ({accept, tag_pop})
                2'b10: begin
                    if (tag_cnt_q == 2'd0) tag0_q <= pc_q;
                    else                   tag1_q <= pc_q;
                    tag_cnt_q <= tag_cnt_q + 2'd1;
                end
                2'b01: begin
                    tag0_q    <= tag1_q;
                    tag_cnt_q <= tag_cnt_q - 2'd1;
                end
                2'b11: begin
                    if (tag_cnt_q == 2'd1) begin
                        tag0_q <= pc_q;
                    end else begin
                        tag0_q <= tag1_q;
                        tag1_q <= pc_q;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_100MHz or negedge arst_n) begin
        if (!arst_n) begin
            fifo_cnt_q <= 2'd0;
            fpc0_q     <= '0;
            fpc1_q     <= '0;
            fin0_q     <= '0;
            fin1_q     <= '0;
        end else if (jump_ena_i) begin
            fifo_cnt_q <= 2'd0;
        end else begin
            case ({fifo_push, fifo_pop})
                2'b10: begin
                    if (fifo_cnt_q == 2'd0) begin
                        fpc0_q <= tag0_q;
                        fin0_q <= imem_rdata_i;
                    end else begin
                        fpc1_q <= tag0_q;
                        fin1_q <= imem_rdata_i;
                    end
                    fifo_cnt_q <= fifo_cnt_q + 2'd1;
                end
                2'b01: begin
                    fpc0_q     <= fpc1_q;
                    fin0_q     <= fin1_q;
                    fifo_cnt_q <= fifo_cnt_q - 2'd1;
                end
                2'b11: begin
                    if (fifo_cnt_q == 2'd1) begin
                        fpc0_q <= tag0_q;
                        fin0_q <= imem_rdata_i;
                    end else begin
                        fpc0_q <= fpc1_q;
                        fin0_q <= fin1_q;
                        fpc1_q <= tag0_q;
                        fin1_q <= imem_rdata_i;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_100MHz or negedge arst_n) begin
        if (!arst_n) begin
            if_valid_o <= 1'b0;
            if_pc_o    <= '0;
            if_inst_o  <= NOP_INST;
        end else if (jump_ena_i) begin
            if_valid_o <= 1'b0;
            if_inst_o  <= NOP_INST;
        end else if (!hold_ena_i) begin
            if (fifo_pop) begin
                if_valid_o <= 1'b1;
                if_pc_o    <= fpc0_q;
                if_inst_o  <= fin0_q;
            end else if (bypass) begin
                if_valid_o <= 1'b1;
                if_pc_o    <= tag0_q;
                if_inst_o  <= imem_rdata_i;
            end else begin
                if_valid_o <= 1'b0;
                if_inst_o  <= NOP_INST;
            end
        end
    end

endmodule

// File: tb/tb_pc_fetch.sv
// tb_pc_fetch: randomized scoreboard bench for pc_fetch.
// The memory model and the expected instruction stream are kept here.
module tb_pc_fetch;

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } ent_t;

    logic        clk_100MHz = 1'b0;
    logic        arst_n;
    logic        hold_ena_i, jump_ena_i;
    logic [31:0] jump_addr_i;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_ready_i, imem_rvalid_i;
    logic [31:0] imem_rdata_i;
    logic        if_valid_o;
    logic [31:0] if_pc_o, if_inst_o;
    logic        misalign_o;

    int          n_chk, n_pass;
    ent_t        sb[$];
    logic [31:0] mq[$];
    logic [31:0] exp_pc;
    bit          exp_mis;
    bit          mon_en;

    pc_fetch dut (
        .clk_100MHz   (clk_100MHz),
        .arst_n       (arst_n),
        .hold_ena_i   (hold_ena_i),
        .jump_ena_i   (jump_ena_i),
        .jump_addr_i  (jump_addr_i),
        .imem_req_o   (imem_req_o),
        .imem_addr_o  (imem_addr_o),
        .imem_ready_i (imem_ready_i),
        .imem_rvalid_i(imem_rvalid_i),
        .imem_rdata_i (imem_rdata_i),
        .if_valid_o   (if_valid_o),
        .if_pc_o      (if_pc_o),
        .if_inst_o    (if_inst_o),
        .misalign_o   (misalign_o)
    );

    always #5 clk_100MHz = ~clk_100MHz;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B9) ^ 32'h1357_2468;
    endfunction

    function automatic logic [31:0] target(input logic [31:0] a);
`ifdef PC_ALIGN_CHECK_EN
        return {a[31:2], 2'b00};
`else
        return a;
`endif
    endfunction

    function automatic bit mis_of(input logic [31:0] a);
`ifdef PC_ALIGN_CHECK_EN
        return a[1:0] != 2'b00;
`else
        return 1'b0;
`endif
    endfunction

    task automatic chk(input bit ok, input string name,
                       input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (ok) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic check_reset(input string tag);
        chk(imem_req_o == 1'b0, {tag, "_req"}, 64'(imem_req_o), 0);
        chk(imem_addr_o == 32'h0, {tag, "_addr"}, 64'(imem_addr_o), 0);
        chk(if_valid_o == 1'b0, {tag, "_valid"}, 64'(if_valid_o), 0);
        chk(if_pc_o == 32'h0, {tag, "_pc"}, 64'(if_pc_o), 0);
        chk(if_inst_o == NOP, {tag, "_inst"}, 64'(if_inst_o), 64'(NOP));
        chk(misalign_o == 1'b0, {tag, "_mis"}, 64'(misalign_o), 0);
    endtask

    // One clock cycle: drive inputs, check the fetch port, advance the model.
    task automatic cyc(input bit h, input bit j, input logic [31:0] ja,
                       input bit rdy, input bit fast, output bit req_seen);
        bit          resp, acc;
        logic [31:0] cur;
        hold_ena_i   = h;
        jump_ena_i   = j;
        jump_addr_i  = ja;
        imem_ready_i = rdy;
        resp = (mq.size() != 0) && (fast || $urandom_range(0, 2) != 0);
        imem_rvalid_i = resp;
        imem_rdata_i  = resp ? mem_word(mq[0]) : $urandom();
        #1;
        req_seen = imem_req_o;
        acc      = imem_req_o && rdy;
        cur      = imem_addr_o;
        if (imem_req_o) begin
            chk(!h && !j, "req_gate", {h, j}, 0);
            chk(imem_addr_o == exp_pc, "fetch_addr",
                64'(imem_addr_o), 64'(exp_pc));
        end
        @(posedge clk_100MHz);
        if (resp) void'(mq.pop_front());
        exp_mis = 1'b0;
        if (j) begin
            sb.delete();
            exp_pc  = target(ja);
            exp_mis = mis_of(ja);
        end else if (acc) begin
            mq.push_back(cur);
            sb.push_back('{pc: exp_pc, inst: mem_word(exp_pc)});
            exp_pc = exp_pc + 32'd4;
        end
        #1;
        chk(misalign_o == exp_mis, "misalign", 64'(misalign_o), 64'(exp_mis));
        chk(mq.size() <= 2, "outstanding", 64'(mq.size()), 2);
    endtask

    // Monitor: every edge decides what if_* must show.
    initial begin
        bit          ph, pj, en, lv;
        logic [31:0] lp, li;
        ent_t        e;
        lv = 0; lp = 0; li = NOP;
        forever begin
            @(posedge clk_100MHz);
            ph = hold_ena_i;
            pj = jump_ena_i;
            en = mon_en;
            #2;
            if (en) begin
                if (pj) begin
                    chk(if_valid_o == 1'b0, "jump_kill", 64'(if_valid_o), 0);
                end else if (ph) begin
                    chk(if_valid_o == lv, "freeze_v", 64'(if_valid_o), 64'(lv));
                    chk({if_pc_o, if_inst_o} == {lp, li}, "freeze_pi",
                        {if_pc_o, if_inst_o}, {lp, li});
                end else if (if_valid_o) begin
                    chk(sb.size() != 0, "unexpected_valid", 64'(if_pc_o), 0);
                    if (sb.size() != 0) begin
                        e = sb.pop_front();
                        chk(if_pc_o == e.pc, "out_pc", 64'(if_pc_o), 64'(e.pc));
                        chk(if_inst_o == e.inst, "out_inst",
                            64'(if_inst_o), 64'(e.inst));
                    end
                end else begin
                    chk(if_inst_o == NOP, "nop_inst", 64'(if_inst_o), 64'(NOP));
                end
            end
            lv = if_valid_o;
            lp = if_pc_o;
            li = if_inst_o;
        end
    end

    initial begin
        bit          r;
        logic [31:0] ja;
        n_chk = 0; n_pass = 0;
        mon_en = 0; exp_pc = 32'h0; exp_mis = 0;
        arst_n = 0; hold_ena_i = 0; jump_ena_i = 0; jump_addr_i = 0;
        imem_ready_i = 0; imem_rvalid_i = 0; imem_rdata_i = 0;
        repeat (3) @(posedge clk_100MHz);
        #1;
        check_reset("rst");
        arst_n = 1;
        mon_en = 1;
        #1;

        // Startup: IDLE edge, first request, valid from the third edge.
        for (int k = 0; k < 6; k++) begin
            cyc(0, 0, 0, 1, 1, r);
            if (k == 0) chk(r == 1'b0, "idle_no_req", 64'(r), 0);
            if (k == 1) chk(r == 1'b1, "first_req", 64'(r), 1);
            chk(if_valid_o == (k >= 2), "first_valid",
                64'(if_valid_o), 64'(k >= 2));
        end
        repeat (4) cyc(0, 0, 0, 1, 1, r);

        // Hold for 4 cycles, then continuous output after release.
        repeat (4) cyc(1, 0, 0, 1, 1, r);
        for (int k = 0; k < 4; k++) begin
            cyc(0, 0, 0, 1, 1, r);
            chk(if_valid_o == 1'b1, "hold_release", 64'(if_valid_o), 1);
        end

        // Memory not ready for 3 cycles: request held at the same address.
        for (int k = 0; k < 3; k++) begin
            cyc(0, 0, 0, 0, 1, r);
            chk(r == 1'b1, "stall_req", 64'(r), 1);
        end
        repeat (4) cyc(0, 0, 0, 1, 1, r);

        // Jump to 0x100 with a request outstanding.
        cyc(0, 1, 32'h100, 1, 1, r);
        chk(if_valid_o == 1'b0, "jump_v0", 64'(if_valid_o), 0);
        cyc(0, 0, 0, 1, 1, r);
        chk(r == 1'b1, "jump_req", 64'(r), 1);
        chk(if_valid_o == 1'b0, "jump_v1", 64'(if_valid_o), 0);
        cyc(0, 0, 0, 1, 1, r);
        chk(if_valid_o && if_pc_o == 32'h100, "jump_first",
            {31'h0, if_valid_o, if_pc_o}, {32'h1, 32'h100});
        repeat (4) cyc(0, 0, 0, 1, 1, r);

        // Jump and hold together.
        cyc(1, 1, 32'h200, 1, 1, r);
        chk(if_valid_o == 1'b0, "jh_valid", 64'(if_valid_o), 0);
        for (int k = 0; k < 2; k++) begin
            cyc(1, 0, 0, 1, 1, r);
            chk(r == 1'b0, "jh_no_req", 64'(r), 0);
        end
        cyc(0, 0, 0, 1, 1, r);
        chk(r == 1'b1, "jh_req", 64'(r), 1);
        repeat (4) cyc(0, 0, 0, 1, 1, r);

        // Misaligned jump and PC wrap-around.
        cyc(0, 1, 32'h102, 1, 1, r);
        repeat (6) cyc(0, 0, 0, 1, 1, r);
        cyc(0, 1, 32'hFFFF_FFF8, 1, 1, r);
        repeat (6) cyc(0, 0, 0, 1, 1, r);

        // Randomized traffic.
        for (int k = 0; k < 3000; k++) begin
            ja = $urandom() & 32'hFFFF_FFFC;
            if ($urandom_range(0, 7) == 0) ja = ja | $urandom_range(1, 3);
            cyc($urandom_range(0, 4) == 0, $urandom_range(0, 15) == 0, ja,
                $urandom_range(0, 3) != 0, 1'b0, r);
        end

        // Reset mid-operation; late responses come back after release.
        cyc(0, 0, 0, 1, 1, r);
        #2;
        mon_en = 0;
        arst_n = 0;
        #1;
        check_reset("midrst");
        sb.delete();
        exp_pc = 32'h0;
        @(posedge clk_100MHz);
        @(posedge clk_100MHz);
        #1;
        arst_n = 1;
        mon_en = 1;
        for (int k = 0; k < 2; k++) begin
            cyc(0, 0, 0, 1, 1, r);
            chk(if_valid_o == 1'b0, "late_ignored", 64'(if_valid_o), 0);
        end
        repeat (8) cyc(0, 0, 0, 1, 1, r);

        // Drain: everything accepted must have been presented.
        repeat (10) cyc(0, 0, 0, 0, 1, r);
        chk(sb.size() == 0, "drain_sb", 64'(sb.size()), 0);
        chk(mq.size() == 0, "drain_mem", 64'(mq.size()), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
